// File: rtl/resistor_rc_network.sv
// resistor_rc_network: clocked resistor pack with per-channel RC settle delay, glitch rejection and pulls.
// OHMS and VOLTS are documentation only and do not influence the logic.
module resistor_rc_network #(
  parameter int CHANNELS = 8,
  parameter int DELAY_CYCLES = 4,
  parameter int PULL_CYCLES = 16,
  parameter logic [CHANNELS-1:0] PULL_MASK = {CHANNELS{1'b1}},
  parameter int OHMS = 0,
  parameter real VOLTS = 5.0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] I,
  input  logic [CHANNELS-1:0] OE,
  output logic [CHANNELS-1:0] O,
  output logic [CHANNELS-1:0] SETTLED,
  output logic [CHANNELS-1:0] EDGE
);
  localparam int MAXL = (DELAY_CYCLES > PULL_CYCLES) ? DELAY_CYCLES : PULL_CYCLES;
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [CW-1:0] DL = CW'(DELAY_CYCLES);
  localparam logic [CW-1:0] PL = CW'(PULL_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (OHMS < 0 || VOLTS < 0.0) begin : g_doc_params_invalid
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic t, o_q, o_d, p_q, p_d, pend_q, pend_d, settled_q, settled_d, edge_q, edge_d;
    logic [CW-1:0] l, n, cnt_q, cnt_d;
    always_comb begin
      t = OE[g] ? I[g] : PULL_MASK[g];
      l = OE[g] ? DL : PL;
      n = (pend_q && p_q == t) ? cnt_q + ONE : ONE;
      o_d = o_q;
      p_d = p_q;
      pend_d = 1'b0;
      cnt_d = '0;
      settled_d = 1'b1;
      edge_d = 1'b0;
      if (t != o_q) begin
        if (n >= l) begin
          o_d = t;
          edge_d = 1'b1;
        end else begin
          p_d = t;
          cnt_d = n;
          pend_d = 1'b1;
          settled_d = 1'b0;
        end
      end
    end
    always_ff @(posedge CLK) begin
      if (RST) begin
        o_q <= PULL_MASK[g];
        p_q <= 1'b0;
        pend_q <= 1'b0;
        cnt_q <= '0;
        settled_q <= 1'b1;
        edge_q <= 1'b0;
      end else begin
        o_q <= o_d;
        p_q <= p_d;
        pend_q <= pend_d;
        cnt_q <= cnt_d;
        settled_q <= settled_d;
        edge_q <= edge_d;
      end
    end
    assign O[g] = o_q;
    assign SETTLED[g] = settled_q;
    assign EDGE[g] = edge_q;
  end
endmodule

// File: tb/tb_resistor_rc_network.sv
// tb_resistor_rc_network: scoreboard bench for the main build and a DELAY_CYCLES=1 build.
module tb_resistor_rc_network;
  localparam logic [7:0] M = 8'hF0;
  localparam logic [3:0] M2 = 4'b0101;
  logic CLK = 1'b0;
  logic RST;
  logic [7:0] I, OE, O, S, E;
  logic [3:0] I2, OE2, O2, S2, E2;
  typedef struct packed {
    logic [7:0] o, s, e;
    logic [3:0] o2, s2, e2;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  bit tog = 1'b0;
  logic [7:0] ci = '0, coe = '0;
  logic [3:0] ci2 = '0, coe2 = '0;
  logic mo[12];
  logic last_t[12];
  int run[12];

  always #5 CLK = ~CLK;

  resistor_rc_network #(.CHANNELS(8), .DELAY_CYCLES(4), .PULL_CYCLES(16), .PULL_MASK(M)) dut_a (
    .CLK(CLK), .RST(RST), .I(I), .OE(OE), .O(O), .SETTLED(S), .EDGE(E));
  resistor_rc_network #(.CHANNELS(4), .DELAY_CYCLES(1), .PULL_CYCLES(3), .PULL_MASK(M2)) dut_b (
    .CLK(CLK), .RST(RST), .I(I2), .OE(OE2), .O(O2), .SETTLED(S2), .EDGE(E2));

  // One sampled edge of one channel: a target must persist for its limit in edges to reach the net.
  function automatic void model_ch(input int k, input logic rst, input logic i, input logic oe,
                                   input logic msk, input int dl, input int pl,
                                   output logic e, output logic s);
    logic t;
    int lim;
    t = oe ? i : msk;
    lim = oe ? dl : pl;
    e = 1'b0;
    s = 1'b1;
    if (rst) begin
      mo[k] = msk;
      run[k] = 0;
    end else if (t == mo[k]) begin
      run[k] = 0;
    end else begin
      run[k] = (run[k] > 0 && last_t[k] == t) ? run[k] + 1 : 1;
      last_t[k] = t;
      if (run[k] >= lim) begin
        mo[k] = t;
        run[k] = 0;
        e = 1'b1;
      end else s = 1'b0;
    end
  endfunction

  task automatic step(input logic rst);
    exp_t x;
    @(negedge CLK);
    if (tog) ci2 = ~ci2;
    RST = rst; I = ci; OE = coe; I2 = ci2; OE2 = coe2;
    for (int k = 0; k < 8; k++) begin
      model_ch(k, rst, ci[k], coe[k], M[k], 4, 16, x.e[k], x.s[k]);
      x.o[k] = mo[k];
    end
    for (int k = 0; k < 4; k++) begin
      model_ch(8 + k, rst, ci2[k], coe2[k], M2[k], 1, 3, x.e2[k], x.s2[k]);
      x.o2[k] = mo[8 + k];
    end
    q.push_back(x);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t x;
    while (!done) begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        cmp("O", O, x.o);
        cmp("SETTLED", S, x.s);
        cmp("EDGE", E, x.e);
        cmp("O_d1", {4'h0, O2}, {4'h0, x.o2});
        cmp("SETTLED_d1", {4'h0, S2}, {4'h0, x.s2});
        cmp("EDGE_d1", {4'h0, E2}, {4'h0, x.e2});
      end
    end
  end

  initial begin : stim
    for (int k = 0; k < 12; k++) begin
      mo[k] = 1'b0; last_t[k] = 1'b0; run[k] = 0;
    end
    RST = 1'b1; I = '0; OE = '0; I2 = '0; OE2 = '0;
    repeat (2) step(1'b1);
    tog = 1'b1; coe2 = 4'hF;
    coe = 8'h07;
    repeat (2) step(1'b0);
    ci[0] = 1'b1;
    repeat (6) step(1'b0);
    ci[1] = 1'b1;
    repeat (3) step(1'b0);
    ci[1] = 1'b0;
    repeat (5) step(1'b0);
    ci[2] = 1'b1;
    repeat (5) step(1'b0);
    coe[2] = 1'b0;
    repeat (9) step(1'b0);
    coe[2] = 1'b1;
    repeat (3) step(1'b0);
    coe[2] = 1'b0;
    repeat (18) step(1'b0);
    coe = 8'hFF; ci = ~M; coe2 = 4'hF;
    step(1'b0);
    step(1'b1);
    coe = 8'h00;
    repeat (3) step(1'b0);
    tog = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(5) == 0) ci[k] = ~ci[k];
        if ($urandom_range(11) == 0) coe[k] = ~coe[k];
      end
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(2) == 0) ci2[k] = ~ci2[k];
        if ($urandom_range(7) == 0) coe2[k] = ~coe2[k];
      end
      step($urandom_range(199) == 0);
    end
    repeat (3) @(posedge CLK);
    done = 1'b1;
    #2;
    cmp("queue_drained", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
